// File: rtl/apu_chan_ctrl_if.sv
// rtl/apu_chan_ctrl_if.sv - register-bus strobes, timing ticks and channel outputs of apu_chan_ctrl
interface apu_chan_ctrl_if #(
    parameter int VOL_BITS = 4
);
    logic                cs;
    logic [1:0]          addr;
    logic                apu_wr;
    logic                ncpu_rd;
    logic                len_tick;
    logic                env_tick;
    logic                ch_active;
    logic                dac_on;
    logic [VOL_BITS-1:0] volume;
    logic [7:0]          poly;
    logic                len_en;
    logic                restart;

    modport master (
        output cs, addr, apu_wr, ncpu_rd, len_tick, env_tick,
        input  ch_active, dac_on, volume, poly, len_en, restart
    );

    modport slave (
        input  cs, addr, apu_wr, ncpu_rd, len_tick, env_tick,
        output ch_active, dac_on, volume, poly, len_en, restart
    );
endinterface

// File: rtl/apu_chan_ctrl.sv
// rtl/apu_chan_ctrl.sv - APU per-channel register file, length counter, volume envelope and trigger
module apu_chan_ctrl #(
    parameter int LEN_BITS = 6,
    parameter int HAS_ENV  = 1,
    parameter int VOL_BITS = 4
) (
    input  logic           clk,
    input  logic           apu_reset,
    inout  wire  [7:0]     d,
    apu_chan_ctrl_if.slave bus
);

    localparam logic [LEN_BITS-1:0] LEN_MAX = '1;

    logic [7:0]          nr2_q, nr2_d;
    logic [7:0]          nr3_q, nr3_d;
    logic                len_en_q, len_en_d;
    logic [LEN_BITS-1:0] len_cnt_q, len_cnt_d;
    logic                expired_q, expired_d;
    logic                active_q, active_d;
    logic                restart_q, restart_d;

    logic                wr_en;
    logic                wr_nr1, wr_nr2, wr_nr3, wr_nr4;
    logic                trigger;
    logic                dac_on;
    logic [7:0]          rdata;

    function automatic logic dac_of(input logic [7:0] v);
        if (HAS_ENV != 0) begin
            return v[7:3] != 5'd0;
        end
        return v[7];
    endfunction

    assign wr_en   = bus.cs & bus.apu_wr;
    assign wr_nr1  = wr_en & (bus.addr == 2'd0);
    assign wr_nr2  = wr_en & (bus.addr == 2'd1);
    assign wr_nr3  = wr_en & (bus.addr == 2'd2);
    assign wr_nr4  = wr_en & (bus.addr == 2'd3);
    assign trigger = wr_nr4 & d[7];
    assign dac_on  = dac_of(nr2_q);

    // Expiry is a separate flag: the counter parks at all-ones and only the
    // tick that arrives while it already sits there kills the channel.
    always_comb begin
        nr2_d     = nr2_q;
        nr3_d     = nr3_q;
        len_en_d  = len_en_q;
        len_cnt_d = len_cnt_q;
        expired_d = expired_q;
        active_d  = active_q;
        restart_d = trigger;

        if (wr_nr2) nr2_d = d;
        if (wr_nr3) nr3_d = d;
        if (wr_nr4) len_en_d = d[6];

        if (wr_nr1) begin
            len_cnt_d = d[LEN_BITS-1:0];
            expired_d = 1'b0;
        end else if (trigger) begin
            if (expired_q) begin
                len_cnt_d = '0;
                expired_d = 1'b0;
            end
        end else if (bus.len_tick && len_en_q && !expired_q) begin
            if (len_cnt_q == LEN_MAX) begin
                expired_d = 1'b1;
                active_d  = 1'b0;
            end else begin
                len_cnt_d = len_cnt_q + LEN_BITS'(1);
            end
        end

        if (trigger) active_d = dac_on;
        // A DAC-off write always has the last word on the enable.
        if (wr_nr2 && !dac_of(d)) active_d = 1'b0;
    end

    always_ff @(posedge clk or posedge apu_reset) begin
        if (apu_reset) begin
            nr2_q     <= 8'h00;
            nr3_q     <= 8'h00;
            len_en_q  <= 1'b0;
            len_cnt_q <= '0;
            expired_q <= 1'b0;
            active_q  <= 1'b0;
            restart_q <= 1'b0;
        end else begin
            nr2_q     <= nr2_d;
            nr3_q     <= nr3_d;
            len_en_q  <= len_en_d;
            len_cnt_q <= len_cnt_d;
            expired_q <= expired_d;
            active_q  <= active_d;
            restart_q <= restart_d;
        end
    end

    generate
        if (HAS_ENV != 0) begin : g_env
            logic [3:0] vol_q, vol_d;
            logic [2:0] per_q, per_d;

            // A period count of 0 or 1 both mean the step is due on this tick.
            always_comb begin
                vol_d = vol_q;
                per_d = per_q;
                if (trigger) begin
                    vol_d = nr2_q[7:4];
                    per_d = nr2_q[2:0];
                end else if (bus.env_tick && (nr2_q[2:0] != 3'd0) && active_q) begin
                    if (per_q > 3'd1) begin
                        per_d = per_q - 3'd1;
                    end else begin
                        per_d = nr2_q[2:0];
                        if (nr2_q[3] && (vol_q != 4'hF)) begin
                            vol_d = vol_q + 4'd1;
                        end else if (!nr2_q[3] && (vol_q != 4'h0)) begin
                            vol_d = vol_q - 4'd1;
                        end
                    end
                end
            end

            always_ff @(posedge clk or posedge apu_reset) begin
                if (apu_reset) begin
                    vol_q <= 4'h0;
                    per_q <= 3'd0;
                end else begin
                    vol_q <= vol_d;
                    per_q <= per_d;
                end
            end

            assign bus.volume = VOL_BITS'(vol_q);
        end else begin : g_no_env
            assign bus.volume = VOL_BITS'(nr2_q[6:5]);
        end
    endgenerate

    always_comb begin
        rdata = 8'hFF;
        case (bus.addr)
            2'd0:    rdata = 8'hFF;
            2'd1:    rdata = nr2_q;
            2'd2:    rdata = nr3_q;
            default: rdata = {1'b1, len_en_q, 6'h3F};
        endcase
    end

    assign d = (bus.cs && !bus.ncpu_rd) ? rdata : 8'hzz;

    assign bus.ch_active = active_q;
    assign bus.dac_on    = dac_on;
    assign bus.poly      = nr3_q;
    assign bus.len_en    = len_en_q;
    assign bus.restart   = restart_q;

endmodule

// File: tb/tb_apu_chan_ctrl.sv
// tb/tb_apu_chan_ctrl.sv - randomized and directed check of apu_chan_ctrl against a behavioural model
module tb_apu_chan_ctrl;

    logic       clk = 1'b0;
    logic       apu_reset;
    logic       tb_oe;
    logic [7:0] tb_dout;
    wire  [7:0] d0;
    wire  [7:0] d1;

    int n_checks;
    int n_pass;

    apu_chan_ctrl_if #(.VOL_BITS(4)) bus0 ();
    apu_chan_ctrl_if #(.VOL_BITS(4)) bus1 ();

    assign d0 = tb_oe ? tb_dout : 8'hzz;
    assign d1 = tb_oe ? tb_dout : 8'hzz;

    apu_chan_ctrl #(.LEN_BITS(6), .HAS_ENV(1), .VOL_BITS(4)) dut_a (
        .clk(clk), .apu_reset(apu_reset), .d(d0), .bus(bus0)
    );
    apu_chan_ctrl #(.LEN_BITS(8), .HAS_ENV(0), .VOL_BITS(4)) dut_b (
        .clk(clk), .apu_reset(apu_reset), .d(d1), .bus(bus1)
    );

    always #5 clk = ~clk;

    // Model state per instance; length is tracked as ticks remaining until expiry.
    const int LENW[2] = '{6, 8};
    const int HASE[2] = '{1, 0};
    int m_nr2[2], m_nr3[2], m_len_en[2], m_rem[2], m_act[2], m_vol[2], m_per[2], m_restart[2];

    task automatic check(string tag, int obs, int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int m_dac(int k, int v);
        if (HASE[k] != 0) return ((v >> 3) != 0) ? 1 : 0;
        return (v >> 7) & 1;
    endfunction

    function automatic int m_volume(int k);
        if (HASE[k] != 0) return m_vol[k];
        return (m_nr2[k] >> 5) & 3;
    endfunction

    function automatic int m_read(int k, int a);
        case (a)
            0:       return 255;
            1:       return m_nr2[k];
            2:       return m_nr3[k];
            default: return 128 + (m_len_en[k] << 6) + 63;
        endcase
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_nr2[k] = 0; m_nr3[k] = 0; m_len_en[k] = 0; m_act[k] = 0;
            m_vol[k] = 0; m_per[k] = 0; m_restart[k] = 0;
            m_rem[k] = 1 << LENW[k];
        end
    endfunction

    function automatic void model_step(int k, bit wr, int a, int dv, bit lt, bit et);
        int  span   = 1 << LENW[k];
        bit  trig   = wr && (a == 3) && (((dv >> 7) & 1) == 1);
        int  nr2    = m_nr2[k];
        int  act    = m_act[k];
        m_restart[k] = trig;
        if (wr && a == 0) begin
            m_rem[k] = span - (dv % span);
        end else if (trig) begin
            if (m_rem[k] == 0) m_rem[k] = span;
        end else if (lt && m_len_en[k] != 0 && m_rem[k] > 0) begin
            m_rem[k]--;
            if (m_rem[k] == 0) m_act[k] = 0;
        end
        if (HASE[k] != 0) begin
            if (trig) begin
                m_vol[k] = nr2 >> 4;
                m_per[k] = nr2 & 7;
            end else if (et && (nr2 & 7) != 0 && act != 0) begin
                if (m_per[k] > 1) m_per[k]--;
                else begin
                    m_per[k] = nr2 & 7;
                    if ((nr2 & 8) != 0) m_vol[k] = (m_vol[k] < 15) ? m_vol[k] + 1 : 15;
                    else                m_vol[k] = (m_vol[k] > 0)  ? m_vol[k] - 1 : 0;
                end
            end
        end
        if (trig) m_act[k] = m_dac(k, nr2);
        if (wr && a == 1) begin
            m_nr2[k] = dv;
            if (m_dac(k, dv) == 0) m_act[k] = 0;
        end
        if (wr && a == 2) m_nr3[k] = dv;
        if (wr && a == 3) m_len_en[k] = (dv >> 6) & 1;
    endfunction

    task automatic cmp_one(string tag, int k, int act, int dac, int vol, int poly, int len_en, int rst_p);
        check($sformatf("%s_%0d_act", tag, k), act, m_act[k]);
        check($sformatf("%s_%0d_dac", tag, k), dac, m_dac(k, m_nr2[k]));
        check($sformatf("%s_%0d_vol", tag, k), vol, m_volume(k));
        check($sformatf("%s_%0d_poly", tag, k), poly, m_nr3[k]);
        check($sformatf("%s_%0d_len_en", tag, k), len_en, m_len_en[k]);
        check($sformatf("%s_%0d_restart", tag, k), rst_p, m_restart[k]);
    endtask

    task automatic compare_all(string tag);
        cmp_one(tag, 0, bus0.ch_active, bus0.dac_on, bus0.volume, bus0.poly, bus0.len_en, bus0.restart);
        cmp_one(tag, 1, bus1.ch_active, bus1.dac_on, bus1.volume, bus1.poly, bus1.len_en, bus1.restart);
    endtask

    task automatic drive(bit c, bit w, int a, int dv, bit rd, bit lt, bit et);
        bus0.cs = c;       bus1.cs = c;
        bus0.apu_wr = w;   bus1.apu_wr = w;
        bus0.addr = 2'(a); bus1.addr = 2'(a);
        bus0.ncpu_rd = !rd; bus1.ncpu_rd = !rd;
        bus0.len_tick = lt; bus1.len_tick = lt;
        bus0.env_tick = et; bus1.env_tick = et;
        tb_oe   = !rd;
        tb_dout = 8'(dv);
    endtask

    task automatic step(bit c, bit w, int a, int dv, bit rd, bit lt, bit et);
        @(negedge clk);
        drive(c, w, a, dv, rd, lt, et);
        @(posedge clk);
        model_step(0, c && w, a, dv, lt, et);
        model_step(1, c && w, a, dv, lt, et);
        #1;
        compare_all("cyc");
        if (c && rd) begin
            check("rd_0", d0, m_read(0, a));
            check("rd_1", d1, m_read(1, a));
        end
    endtask

    initial begin
        int r, a, dv;
        bit lt, et;
        n_checks = 0;
        n_pass   = 0;
        apu_reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all("rst");
        @(negedge clk);
        apu_reset = 1'b0;

        // Trigger, readback of write-only bits
        step(1, 1, 1, 'hF0, 0, 0, 0);
        step(1, 1, 3, 'h80, 0, 0, 0);
        check("t1_restart", bus0.restart, 1);
        check("t1_act", bus0.ch_active, 1);
        check("t1_vol", bus0.volume, 15);
        step(1, 0, 3, 0, 1, 0, 0);
        check("t1_rd_nr4", d0, 'hBF);
        check("t1_restart_once", bus0.restart, 0);
        step(1, 0, 0, 0, 1, 0, 0);
        check("t1_rd_nr1", d0, 'hFF);

        // Length expiry at all-ones, no wrap, reload on retrigger
        step(1, 1, 0, 'h3E, 0, 0, 0);
        step(1, 1, 3, 'hC0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        check("t2_tick1_act", bus0.ch_active, 1);
        step(0, 0, 0, 0, 0, 1, 0);
        check("t2_tick2_act", bus0.ch_active, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        check("t2_tick3_act", bus0.ch_active, 0);
        step(1, 1, 3, 'hC0, 0, 0, 0);
        check("t2_retrig_act", bus0.ch_active, 1);
        repeat (63) step(0, 0, 0, 0, 0, 1, 0);
        check("t2_full_len_act", bus0.ch_active, 1);
        step(0, 0, 0, 0, 0, 1, 0);
        check("t2_full_len_exp", bus0.ch_active, 0);

        // Envelope up, period 2, saturating at 15
        step(1, 1, 1, 'h0A, 0, 0, 0);
        step(1, 1, 3, 'h80, 0, 0, 0);
        for (int i = 1; i <= 34; i++) begin
            step(0, 0, 0, 0, 0, 0, 1);
            check("t3_vol", bus0.volume, (i / 2 > 15) ? 15 : i / 2);
        end

        // DAC off kills the channel and blocks re-enable
        step(1, 1, 1, 'hF1, 0, 0, 0);
        step(1, 1, 3, 'h80, 0, 0, 0);
        check("t4_act_on", bus0.ch_active, 1);
        step(1, 1, 1, 'h07, 0, 0, 0);
        check("t4_act_off", bus0.ch_active, 0);
        check("t4_dac_off", bus0.dac_on, 0);
        step(1, 1, 3, 'h80, 0, 0, 0);
        check("t4_restart", bus0.restart, 1);
        check("t4_act_stays", bus0.ch_active, 0);

        // Coincident NRx1 write with len_tick; trigger with env_tick
        step(1, 1, 1, 'hF0, 0, 0, 0);
        step(1, 1, 3, 'hC0, 0, 0, 0);
        step(1, 1, 0, 'h3D, 0, 1, 0);
        repeat (2) step(0, 0, 0, 0, 0, 1, 0);
        check("t5_len_act", bus0.ch_active, 1);
        step(0, 0, 0, 0, 0, 1, 0);
        check("t5_len_exp", bus0.ch_active, 0);
        step(1, 1, 1, 'h0B, 0, 0, 0);
        step(1, 1, 3, 'h80, 0, 0, 1);
        repeat (2) step(0, 0, 0, 0, 0, 0, 1);
        check("t5_env_hold", bus0.volume, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        check("t5_env_step", bus0.volume, 1);

        // 8-bit length, static volume shift code
        step(1, 1, 1, 'hC0, 0, 0, 0);
        step(1, 1, 0, 'h00, 0, 0, 0);
        step(1, 1, 3, 'hC0, 0, 0, 0);
        for (int i = 1; i <= 256; i++) begin
            step(0, 0, 0, 0, 0, 1, (i % 3) == 0);
            if (i == 255) check("t6_act_255", bus1.ch_active, 1);
            if (i == 256) check("t6_act_256", bus1.ch_active, 0);
            if ((i % 64) == 0) check("t6_vol", bus1.volume, 2);
        end

        // Reset during a trigger write: no restart pulse
        step(1, 1, 1, 'hF0, 0, 0, 0);
        @(negedge clk);
        drive(1, 1, 3, 'h80, 0, 0, 0);
        #2 apu_reset = 1'b1;
        #1;
        check("mrst_async_act", bus0.ch_active, 0);
        @(posedge clk);
        #1;
        check("mrst_restart", bus0.restart, 0);
        model_reset();
        compare_all("mrst");
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        apu_reset = 1'b0;

        for (int n = 0; n < 3000; n++) begin
            r  = $urandom_range(0, 99);
            lt = ($urandom_range(0, 3) == 0);
            et = ($urandom_range(0, 3) == 0);
            dv = $urandom_range(0, 255);
            a  = $urandom_range(0, 3);
            if (r < 8) begin
                if ($urandom_range(0, 1) == 1) dv = 255 - $urandom_range(0, 4);
                step(1, 1, 0, dv, 0, lt, et);
            end else if (r < 14) step(1, 1, 1, dv, 0, lt, et);
            else if (r < 18) step(1, 1, 2, dv, 0, lt, et);
            else if (r < 26) step(1, 1, 3, dv, 0, lt, et);
            else if (r < 34) step(1, 0, a, 0, 1, lt, et);
            else if (r < 37) step(0, 1, a, dv, 0, lt, et);
            else step(0, 0, 0, 0, 0, lt, et);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/apu_chan_ctrl.md
Name: apu_chan_ctrl

Overview:
Parametrised per-channel control block for the APU: four CPU-visible registers (NRx1 length, NRx2 envelope, NRx3 poly/freq, NRx4 control), a length counter, a volume envelope unit and trigger logic. It generalises the fixed noise-channel register file so one block serves every channel: length width and envelope presence are set by parameters. It sits between the APU register decode and the channel waveform generator, which consumes volume, poly and the restart pulse.

Parameters:
LEN_BITS, 6, length-counter width (6 for pulse/noise channels, 8 for wave channel); legal range 6..8
HAS_ENV, 1, 1 = NRx2 is an envelope register; 0 = NRx2 bits [6:5] are a volume shift code and no envelope unit is built
VOL_BITS, 4, width of the volume output

Ports:
clk  in  1  APU clock; all state updates on rising edge
apu_reset  in  1  asynchronous, active-high reset
d  inout  8  CPU data bus; driven only during a selected read
cs  in  1  channel register block selected
addr  in  2  register select: 0=NRx1, 1=NRx2, 2=NRx3, 3=NRx4
apu_wr  in  1  write strobe, sampled on clk when cs=1
ncpu_rd  in  1  active-low read enable
len_tick  in  1  one-cycle 256 Hz length strobe
env_tick  in  1  one-cycle 64 Hz envelope strobe
ch_active  out  1  channel enabled
dac_on  out  1  DAC enable (NRx2 bits [7:3] nonzero; HAS_ENV=0: NRx2[7])
volume  out  VOL_BITS  current volume (HAS_ENV=0: zero-extended NRx2[6:5] shift code)
poly  out  8  NRx3 contents
len_en  out  1  NRx4 bit 6
restart  out  1  one-cycle pulse on trigger

Behaviour:
- Reset (async): all registers 0, length counter 0, envelope period counter 0, volume 0, ch_active 0, restart 0, d released (Z).
- Writes occur on the clk edge with cs & apu_wr.
- NRx1 write: length counter <= d[LEN_BITS-1:0]. Remaining NRx1 bits are not stored.
- NRx2 write: stored; if new dac_on=0, ch_active <= 0 that cycle.
- NRx3 write: stored, reflected on poly next cycle.
- NRx4 write: len_en <= d[6]; if d[7]=1, trigger.
- Trigger: restart=1 for exactly one cycle. ch_active <= dac_on. Volume <= NRx2[7:4]. Envelope period counter <= NRx2[2:0]. If length counter is all-ones (expired), it reloads to 0 (full length). d[7] is not stored.
- Length counter: on len_tick with len_en=1 and counter not expired, it increments. The transition all-ones -> expired sets ch_active <= 0. The counter holds at all-ones (no wrap). With len_en=0 the tick is ignored.
- Envelope (HAS_ENV=1): on env_tick with NRx2[2:0]!=0 and ch_active=1, the period counter decrements. On reaching 0 it reloads NRx2[2:0] and volume steps by 1: up if NRx2[3]=1, down otherwise. Volume saturates at 15 (up) or 0 (down) with no wrap. Period 0 freezes the envelope.
- Simultaneous events:
  - Write to NRx1 in the same cycle as len_tick: the write wins.
  - Trigger in the same cycle as len_tick or env_tick: the trigger wins and the tick is discarded.
  - NRx2 write with DAC off plus trigger in the same cycle: ch_active ends 0.
- Readback: with cs=1 and ncpu_rd=0, d is driven combinationally. Unreadable bits read 1.
  - NRx1 = 0xFF.
  - NRx2 = stored value.
  - NRx3 = stored value.
  - NRx4 = {1, len_en, 6'b111111}.
- HAS_ENV=0: volume is static, env_tick is ignored, and trigger does not load volume.
- apu_reset asserted mid-operation aborts immediately to the reset state. restart is never emitted for an in-flight trigger.

Test Plan:
1. Reset -> write NRx2=0xF0, NRx4=0x80 -> restart pulses 1 cycle; ch_active=1; volume=15; reads: NRx4=0xBF, NRx1=0xFF.
2. LEN_BITS=6: NRx1=0x3E, NRx4=0xC0, 2 len_ticks -> ch_active falls after tick 2; counter=0x3F. A 3rd tick causes no change. Re-trigger -> counter=0 and ch_active=1.
3. NRx2=0x0A (vol 0, up, period 2), trigger, 34 env_ticks -> volume increments every 2nd tick and saturates at 15 (reached after tick 30, then holds).
4. NRx2=0xF1 active, then write NRx2=0x07 -> ch_active=0 next cycle; dac_on=0. Trigger -> ch_active stays 0 and restart still pulses.
5. NRx1 write coincident with len_tick -> counter = written value, not incremented. Trigger coincident with env_tick -> period counter = NRx2[2:0].
6. LEN_BITS=8, HAS_ENV=0: NRx2=0xC0, 256-step length run from NRx1=0 -> ch_active drops on tick 256. volume=2, constant through env_ticks.
